// File: rtl/sr_pulse_ctrl.sv
// Debounced, arbitrated set/clear command pulses for a downstream SR flip-flop.
// Optional conflict statistics counter enabled by defining SR_PULSE_CTRL_STATS_EN.
module sr_pulse_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_btn,
    input  logic       clr_btn,
    output logic       S,
    output logic       R,
    output logic       busy,
    output logic       conflict,
    output logic [7:0] stat_conflicts
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    logic [1:0]       btn;
    logic [1:0]       meta_p0;
    logic [1:0]       sync_p1;
    logic [1:0]       deb;
    logic [1:0]       deb_d;
    logic [1:0]       req;
    logic [CNT_W-1:0] cnt [2];
    logic             set_req;
    logic             clr_req;
    logic             coincide;
    state_t           state;
    logic [HOLD_W-1:0] hold;

    assign btn = {clr_btn, set_btn};

    // Bit 0 carries the set path, bit 1 the clear path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_p0 <= '0;
            sync_p1 <= '0;
            deb     <= '0;
            deb_d   <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            meta_p0 <= btn;
            sync_p1 <= meta_p0;
            deb_d   <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= sync_p1[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign req      = deb & ~deb_d;
    assign set_req  = req[0];
    assign clr_req  = req[1];
    assign coincide = (state == IDLE) && set_req && clr_req;

    // Only IDLE accepts requests, so S and R can never be high together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold     <= '0;
            S        <= 1'b0;
            R        <= 1'b0;
            busy     <= 1'b0;
            conflict <= 1'b0;
        end else begin
            S        <= 1'b0;
            R        <= 1'b0;
            conflict <= 1'b0;
            case (state)
                IDLE: begin
                    if (set_req && clr_req) begin
                        conflict <= 1'b1;
                    end else if (set_req) begin
                        state <= PULSE_S;
                        S     <= 1'b1;
                        busy  <= 1'b1;
                    end else if (clr_req) begin
                        state <= PULSE_R;
                        R     <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                PULSE_S, PULSE_R: begin
                    state <= LOCKOUT;
                    hold  <= HOLD_LOAD;
                    busy  <= 1'b1;
                end
                LOCKOUT: begin
                    if (hold == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        hold <= hold - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SR_PULSE_CTRL_STATS_EN
    logic [7:0] stat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= 8'd0;
        end else if (coincide && (stat_q != 8'hFF)) begin
            stat_q <= stat_q + 8'd1;
        end
    end

    assign stat_conflicts = stat_q;
`else
    logic unused_coincide;
    assign unused_coincide = coincide;
    assign stat_conflicts  = 8'd0;
`endif

endmodule

// File: doc/sr_pulse_ctrl.md
# sr_pulse_ctrl

Upstream command stage for the SR flip-flop. It takes two asynchronous, bouncy request lines (set button, clear button) and synchronizes and debounces them. Each debounced rising edge becomes a single-cycle `S` or `R` pulse. A small arbitration FSM guarantees `S` and `R` are never high together, so the forbidden S=R=1 input can never reach the downstream SRFF. `S`/`R` connect directly to the SRFF's `S`/`R` ports on the same `clk`.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a debounced level changes (min 2).
- `HOLDOFF_CYCLES`, default 3: cycles spent in LOCKOUT after every issued pulse (min 1).
- `clk` input 1: system clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `set_btn` input 1: asynchronous set request, level, may bounce.
- `clr_btn` input 1: asynchronous clear request, level, may bounce.
- `S` output 1: registered one-cycle set pulse to the SRFF.
- `R` output 1: registered one-cycle reset pulse to the SRFF.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `conflict` output 1: registered one-cycle pulse when set and clear edges coincide.
- `stat_conflicts` output 8: saturating conflict count (see Configuration).

## Operation
- Per input: 2-flop synchronizer, then debouncer (counter `cnt`, level `deb`), then edge register `deb_d`.
- Debounce rules:
  - If sync out equals `deb`: `cnt` is set to 0.
  - Otherwise `cnt` increments.
  - When `cnt == DEBOUNCE_CYCLES-1` and sync out still differs: `deb` takes sync out and `cnt` is set to 0.
- Request: `req = deb & ~deb_d` (rising edge only). Falling edges are debounced identically but generate nothing.
- FSM states: IDLE, PULSE_S, PULSE_R, LOCKOUT.
  - IDLE, set_req only: go to PULSE_S, `S` goes to 1.
  - IDLE, clr_req only: go to PULSE_R, `R` goes to 1.
  - IDLE, both reqs: stay IDLE, `conflict` goes to 1, no pulse.
  - PULSE_S/PULSE_R: go to LOCKOUT, `S`/`R` go to 0, holdoff counter loaded with `HOLDOFF_CYCLES-1`.
  - LOCKOUT: decrement the counter; at 0, go to IDLE.
- Requests arriving in PULSE_* or LOCKOUT are dropped, not queued.
- Invariant: `S & R` is never 1 on any cycle.
- Reset values: all synchronizer flops, `deb`, `deb_d`, and counters are 0; state is IDLE; `S`, `R`, `busy`, `conflict` are 0; `stat_conflicts` is 0.

## Timing
- Latency: take the first `clk` edge that samples the button high as edge 0. `S`/`R` rises at edge `DEBOUNCE_CYCLES+2` and falls one edge later. Default: rises at edge 6.
- Glitch filtering: a button high for fewer than `DEBOUNCE_CYCLES` consecutive synchronized cycles produces no pulse.
- Holdoff: `busy` is high from the pulse edge through `HOLDOFF_CYCLES` cycles after the pulse falls. Default: busy for 4 cycles total.
- Conflict: `conflict` is high for exactly one cycle, aligned to where the pulse would have been. `busy` stays 0.
- Reset mid-operation: `rst_n` low clears every flop and output immediately, independent of `clk`, and any in-flight pulse is cut off.
- Button held through reset release: the button debounces from `deb=0` and issues exactly one pulse after release.
- Button held continuously: one pulse only. A new pulse requires release (debounced low), then a new debounced high.

## Configuration
- `SR_PULSE_CTRL_STATS_EN` defined:
  - `stat_conflicts` increments on every `conflict` pulse.
  - It saturates at 255 and clears only on reset.
- Undefined: no counter logic is built; `stat_conflicts` is tied to 8'd0. The port always exists.

## Test plan
- Clean set: `set_btn` high for 10 cycles from edge 0 -> `S`=1 only in cycle 6–7, `R`=0 throughout, `busy` high for 4 cycles.
- Bounce: `set_btn` toggles 1,0,1,0 every cycle, then holds high -> no pulse during toggling, exactly one `S` pulse 6 edges after the final rise is first sampled.
- Simultaneous: `set_btn` and `clr_btn` rise on the same edge -> `S`=`R`=0 always, `conflict`=1 for one cycle at edge 6, `stat_conflicts`=1 with the macro defined and 0 without.
- Lockout drop: clear edge debounced 2 cycles after an `S` pulse -> no `R` pulse. A second clear press after `busy` falls -> `R` pulse.
- Reset mid-pulse: `rst_n` low during a cycle where `S`=1 -> `S` goes to 0 asynchronously, state IDLE, `busy`=0.
- Saturation (macro defined): 300 coincident presses -> `stat_conflicts`=255. Assert `S&R`==0 on every cycle of every test.
